ahb_sram_slave: RTL and testbench

AHB-Lite SRAM slave that sits directly downstream of the AHB interconnect, one instance per slave port. It takes the address phase the interconnect drives on its slave interface and performs byte, halfword and word reads and writes to a local memory. Each transfer can be stretched by a programmable number of wait states. Misaligned or oversized transfers receive the standard two-cycle ERROR response.

---
 rtl/ahb_sram_slave_pkg.sv | 48 ++++
 rtl/ahb_sram_slave_if.sv | 29 ++
 rtl/ahb_sram_array.sv | 20 ++
 rtl/ahb_sram_slave.sv | 105 ++++++++++
 tb/tb_ahb_sram_slave.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite types, FSM state encoding and lane helpers for the SRAM slave.
package ahb_sram_slave_pkg;

  localparam int SLAVE_MEMORY_SIZE = 10;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } ahb_htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } ahb_hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } ahb_hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb_sram_state_e;

  // Byte lanes touched by an aligned transfer of the given size at byte offset off.
  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Oversized or misaligned transfers get the two-cycle ERROR response.
  function automatic logic addr_error(input logic [2:0] size, input logic [1:0] off);
    return (size > HSIZE_WORD) ||
           (size == HSIZE_HALF && off[0]) ||
           (size == HSIZE_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave port bundle as seen between the interconnect and one slave.
interface ahb_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hselx;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [3:0]            hprot;
  logic                  hmastlock;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hreadyout;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport slave (
    input  hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hready, hwdata,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hready, hwdata,
    input  hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_array.sv
// Word-wide storage with per-byte write enables, synchronous write, asynchronous read.
module ahb_sram_array #(
  parameter int WA = 8
) (
  input  logic          hclk,
  input  logic [WA-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**WA];

  // Commit only the enabled byte lanes; contents are intentionally not reset.
  always_ff @(posedge hclk) begin
    for (int i = 0; i < 4; i++)
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: address-phase capture, error check, wait-state FSM, lane decode.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_SIZE_LOG2 = SLAVE_MEMORY_SIZE,
  parameter int WAIT_STATES   = 0
) (
  input logic            hclk,
  input logic            hresetn,
  ahb_sram_slave_if.slave bus
);
  localparam int         WA = MEM_SIZE_LOG2 - 2;
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  ahb_sram_state_e state, state_nxt;
  logic [2:0]      cnt, cnt_nxt;
  logic [WA-1:0]   lat_waddr;
  logic [1:0]      lat_off;
  logic [1:0]      lat_size;
  logic            lat_write;

  logic            accept, open, take, err_in;
  logic [3:0]      be;
  logic [31:0]     rdata;

  // Attribute-only inputs and the address bits above the window are not decoded.
  logic unused_ok;
  assign unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock,
                       bus.haddr[ADDR_WIDTH-1:MEM_SIZE_LOG2]};

  assign accept = bus.hselx && bus.hready && bus.htrans[1];
  // A new address phase may only land while no stalling data phase is in flight.
  assign open   = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign take   = accept && open;
  assign err_in = addr_error(bus.hsize, bus.haddr[1:0]);

  // State, wait counter and address-phase fields; reset abandons any pending transfer.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_waddr <= '0;
      lat_off   <= '0;
      lat_size  <= '0;
      lat_write <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (take) begin
        lat_waddr <= bus.haddr[MEM_SIZE_LOG2-1:2];
        lat_off   <= bus.haddr[1:0];
        lat_size  <= bus.hsize[1:0];
        lat_write <= bus.hwrite && !err_in;
      end
    end
  end

  // Next-state decode plus registered-state-only outputs.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    bus.hreadyout = 1'b1;
    bus.hresp     = HRESP_OKAY;
    bus.hrdata    = '0;
    case (state)
      ST_WAIT: begin
        bus.hreadyout = 1'b0;
        cnt_nxt       = cnt - 3'd1;
        if (cnt == 3'd1) state_nxt = ST_DATA;
      end
      ST_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = HRESP_ERROR;
        state_nxt     = ST_ERR2;
      end
      default: begin
        if (state == ST_ERR2) bus.hresp = HRESP_ERROR;
        if (state == ST_DATA) bus.hrdata = rdata;
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        if (take) begin
          if (err_in)         state_nxt = ST_ERR1;
          else if (WS == '0)  state_nxt = ST_DATA;
          else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WS;
          end
        end
      end
    endcase
  end

  // Writes land on the edge that closes the final OKAY data-phase cycle.
  assign be = (state == ST_DATA && lat_write) ? lane_enables(lat_size, lat_off) : 4'b0000;

  ahb_sram_array #(.WA(WA)) u_array (
    .hclk  (hclk),
    .addr  (lat_waddr),
    .be    (be),
    .wdata (bus.hwdata[31:0]),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: table vectors, hand sequences and random traffic vs a byte-level model.
module tb_ahb_sram_slave;
  logic        hclk = 1'b0;
  logic        hresetn;
  logic        sel0, sel3;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;

  int errors = 0;
  int checks = 0;

  logic [7:0] mdl [2][1024];

  always #5 hclk = ~hclk;

  ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b0 ();
  ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

  assign b0.hselx = sel0;      assign b3.hselx = sel3;
  assign b0.haddr = haddr;     assign b3.haddr = haddr;
  assign b0.htrans = htrans;   assign b3.htrans = htrans;
  assign b0.hwrite = hwrite;   assign b3.hwrite = hwrite;
  assign b0.hsize = hsize;     assign b3.hsize = hsize;
  assign b0.hburst = 3'b000;   assign b3.hburst = 3'b000;
  assign b0.hprot = 4'b0011;   assign b3.hprot = 4'b0011;
  assign b0.hmastlock = 1'b0;  assign b3.hmastlock = 1'b0;
  assign b0.hwdata = hwdata;   assign b3.hwdata = hwdata;
  assign b0.hready = b0.hreadyout;
  assign b3.hready = b3.hreadyout;

  ahb_sram_slave #(.WAIT_STATES(0)) u0 (.hclk(hclk), .hresetn(hresetn), .bus(b0));
  ahb_sram_slave #(.WAIT_STATES(3)) u3 (.hclk(hclk), .hresetn(hresetn), .bus(b3));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int t);
    return (t == 0) ? b0.hreadyout : b3.hreadyout;
  endfunction
  function automatic logic rsp(input int t);
    return (t == 0) ? b0.hresp : b3.hresp;
  endfunction
  function automatic logic [31:0] rdd(input int t);
    return (t == 0) ? b0.hrdata : b3.hrdata;
  endfunction

  function automatic bit is_err(input logic [2:0] size, input logic [31:0] a);
    return (size > 3'd2) || (size == 3'd1 && a[0]) || (size == 3'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] mword(input int d, input logic [31:0] a);
    int b;
    b = int'(a[9:0]) & ~3;
    return {mdl[d][b+3], mdl[d][b+2], mdl[d][b+1], mdl[d][b]};
  endfunction

  // Model: a byte-addressed memory; an OKAY write stores each covered byte from its lane.
  task automatic mapply(input int d, input bit wr, input logic [31:0] a,
                        input logic [2:0] size, input logic [31:0] wd);
    int b;
    if (wr && !is_err(size, a))
      for (int k = 0; k < (1 << size); k++) begin
        b = int'(a[9:0]) + k;
        mdl[d][b] = wd[8*(b%4) +: 8];
      end
  endtask

  // One isolated transfer: address phase, then data phase until hreadyout rises.
  task automatic ahb(input int t, input bit wr, input logic [31:0] a, input logic [2:0] size,
                     input logic [31:0] wd, output logic [31:0] rd, output logic rs,
                     output logic first_rs, output int waits);
    @(negedge hclk);
    sel0 = (t == 0); sel3 = (t != 0);
    htrans = 2'b10; haddr = a; hwrite = wr; hsize = size;
    @(posedge hclk);
    @(negedge hclk);
    sel0 = 1'b0; sel3 = 1'b0; htrans = 2'b00; hwdata = wd;
    waits = 0; first_rs = 1'b0;
    while (rdy(t) == 1'b0 && waits < 20) begin
      if (waits == 0) first_rs = rsp(t);
      waits++;
      @(negedge hclk);
    end
    if (waits >= 20) chk("timeout_hreadyout", 32'(waits), 32'd0);
    rd = rdd(t);
    rs = rsp(t);
    @(posedge hclk);
  endtask

  typedef struct {
    int          t;
    bit          wr;
    logic [31:0] a;
    logic [2:0]  size;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_waits;
  } vec_t;

  initial begin
    vec_t        tbl [14];
    logic [31:0] rd, wd, a;
    logic        rs, frs;
    int          w, t, d;
    bit          wr, e;
    logic [2:0]  sz;

    tbl[0]  = '{0, 1, 32'h010, 3'd2, 32'h11223344, 32'h0,        0, 0};
    tbl[1]  = '{0, 1, 32'h013, 3'd0, 32'hAA000000, 32'h0,        0, 0};
    tbl[2]  = '{0, 0, 32'h010, 3'd2, 32'h0,        32'hAA223344, 0, 0};
    tbl[3]  = '{0, 1, 32'h012, 3'd1, 32'h55660000, 32'h0,        0, 0};
    tbl[4]  = '{0, 0, 32'h010, 3'd2, 32'h0,        32'h55663344, 0, 0};
    tbl[5]  = '{0, 1, 32'h011, 3'd1, 32'hFFFFFFFF, 32'h0,        1, 1};
    tbl[6]  = '{0, 0, 32'h010, 3'd2, 32'h0,        32'h55663344, 0, 0};
    tbl[7]  = '{0, 1, 32'h010, 3'd3, 32'hFFFFFFFF, 32'h0,        1, 1};
    tbl[8]  = '{0, 1, 32'h016, 3'd2, 32'hFFFFFFFF, 32'h0,        1, 1};
    tbl[9]  = '{0, 0, 32'h010, 3'd2, 32'h0,        32'h55663344, 0, 0};
    tbl[10] = '{3, 1, 32'h020, 3'd2, 32'hCAFEF00D, 32'h0,        0, 3};
    tbl[11] = '{3, 0, 32'h020, 3'd2, 32'h0,        32'hCAFEF00D, 0, 3};
    tbl[12] = '{3, 1, 32'h021, 3'd1, 32'hFFFFFFFF, 32'h0,        1, 1};
    tbl[13] = '{3, 0, 32'h020, 3'd2, 32'h0,        32'hCAFEF00D, 0, 3};

    hresetn = 1'b0; sel0 = 0; sel3 = 0; haddr = 0; hwdata = 0;
    htrans = 2'b00; hwrite = 0; hsize = 3'd0;
    #1;
    chk("reset_hreadyout0", 32'(b0.hreadyout), 32'd1);
    chk("reset_hresp0",     32'(b0.hresp),     32'd0);
    chk("reset_hrdata0",    b0.hrdata,         32'd0);
    chk("reset_hreadyout3", 32'(b3.hreadyout), 32'd1);
    chk("reset_hresp3",     32'(b3.hresp),     32'd0);
    chk("reset_hrdata3",    b3.hrdata,         32'd0);
    repeat (2) @(negedge hclk);
    hresetn = 1'b1;

    // Give both memories known contents over the 64-byte test window.
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 2; k++) begin
        wd = $urandom;
        ahb(k * 3, 1, 32'(4 * i), 3'd2, wd, rd, rs, frs, w);
        mapply(k, 1, 32'(4 * i), 3'd2, wd);
      end

    for (int i = 0; i < 14; i++) begin
      ahb(tbl[i].t, tbl[i].wr, tbl[i].a, tbl[i].size, tbl[i].wd, rd, rs, frs, w);
      chk($sformatf("vec%0d_hresp", i),     32'(rs),  32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_first_resp", i), 32'(frs), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_waits", i),     32'(w),   32'(tbl[i].exp_waits));
      if (!tbl[i].wr && !tbl[i].exp_err) chk($sformatf("vec%0d_hrdata", i), rd, tbl[i].exp_rd);
      mapply(tbl[i].t == 0 ? 0 : 1, tbl[i].wr, tbl[i].a, tbl[i].size, tbl[i].wd);
    end

    // Back-to-back write then read of the same word with no wait states.
    @(negedge hclk);
    sel0 = 1; htrans = 2'b10; haddr = 32'h010; hwrite = 1; hsize = 3'd2;
    @(posedge hclk);
    @(negedge hclk);
    hwdata = 32'hDEADBEEF; hwrite = 0;
    chk("b2b_write_nostall", 32'(b0.hreadyout), 32'd1);
    @(posedge hclk);
    @(negedge hclk);
    sel0 = 0; htrans = 2'b00;
    chk("b2b_read_hreadyout", 32'(b0.hreadyout), 32'd1);
    chk("b2b_read_hresp",     32'(b0.hresp),     32'd0);
    chk("b2b_read_hrdata",    b0.hrdata,         32'hDEADBEEF);
    @(posedge hclk);
    mapply(0, 1, 32'h010, 3'd2, 32'hDEADBEEF);

    // Selected IDLE/BUSY and unselected NONSEQ must not start a transfer.
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      sel0 = (k < 2); htrans = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b10;
      haddr = 32'h010; hwrite = 1; hsize = 3'd2;
      @(posedge hclk);
      @(negedge hclk);
      sel0 = 0; htrans = 2'b00; hwdata = 32'h0BAD0BAD;
      chk($sformatf("noxfer%0d_hreadyout", k), 32'(b0.hreadyout), 32'd1);
      chk($sformatf("noxfer%0d_hresp", k),     32'(b0.hresp),     32'd0);
      @(posedge hclk);
    end
    ahb(0, 0, 32'h010, 3'd2, 0, rd, rs, frs, w);
    chk("noxfer_mem_untouched", rd, 32'hDEADBEEF);

    // Random traffic on both slaves against the byte model.
    for (int i = 0; i < 80; i++) begin
      t  = ($urandom_range(0, 1) == 0) ? 0 : 3;
      d  = (t == 0) ? 0 : 1;
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 63));
      sz = 3'($urandom_range(0, 3));
      wd = $urandom;
      e  = is_err(sz, a);
      ahb(t, wr, a, sz, wd, rd, rs, frs, w);
      chk($sformatf("rnd%0d_hresp", i), 32'(rs), 32'(e));
      chk($sformatf("rnd%0d_waits", i), 32'(w),  e ? 32'd1 : 32'(t));
      if (!wr && !e) chk($sformatf("rnd%0d_hrdata", i), rd, mword(d, a));
      mapply(d, wr, a, sz, wd);
    end

    // Reset during the wait states of a write drops the write.
    @(negedge hclk);
    sel3 = 1; htrans = 2'b10; haddr = 32'h020; hwrite = 1; hsize = 3'd2;
    @(posedge hclk);
    @(negedge hclk);
    sel3 = 0; htrans = 2'b00; hwdata = 32'h12345678;
    chk("rst_mid_in_wait", 32'(b3.hreadyout), 32'd0);
    #2 hresetn = 1'b0;
    #1;
    chk("rst_mid_hreadyout", 32'(b3.hreadyout), 32'd1);
    chk("rst_mid_hresp",     32'(b3.hresp),     32'd0);
    chk("rst_mid_hrdata",    b3.hrdata,         32'd0);
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    ahb(3, 0, 32'h020, 3'd2, 0, rd, rs, frs, w);
    chk("rst_after_hrdata", rd, mword(1, 32'h020));
    chk("rst_after_waits",  32'(w), 32'd3);
    chk("rst_after_hresp",  32'(rs), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
